// File: rtl/core_run_ctrl.sv
// core_run_ctrl: load-and-run sequencer for the pipelined RV64I datapath.
// Holds the core in reset while a program streams into IMEM over a valid/ready
// port, releases it for a bounded number of cycles (or until halt), then
// freezes the pipeline so register-file and PC state remain observable.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                begin a load+run sequence (honoured in IDLE/DONE)
//   ld_valid/ld_data/ld_last, ld_ready   program word stream
//   run_cycles           run budget, sampled in RELEASE
//   halt                 datapath halt indication (honoured in RUN)
//   imem_we/imem_addr/imem_wdata         IMEM write port (combinational)
//   core_rst, core_stall datapath reset and pipeline freeze
//   busy, done           sequence in progress / one-cycle completion pulse
//   status               0 none, 1 halted, 2 budget, 3 overflow
//   cycles_used          RUN cycles consumed by the last sequence
module core_run_ctrl #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned CYC_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          ld_valid,
  input  logic [INSTR_W-1:0]            ld_data,
  input  logic                          ld_last,
  output logic                          ld_ready,
  input  logic [CYC_W-1:0]              run_cycles,
  input  logic                          halt,
  output logic                          imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  output logic [INSTR_W-1:0]            imem_wdata,
  output logic                          core_rst,
  output logic                          core_stall,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    status,
  output logic [CYC_W-1:0]              cycles_used
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  typedef enum logic [2:0] {StIdle, StLoad, StRelease, StRun, StDone} state_e;
  typedef enum logic [1:0] {StatNone, StatHalted, StatBudget, StatOverflow} status_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CYC_W-1:0] budget_q, budget_d;
  logic [CYC_W-1:0] used_q, used_d;
  status_e          status_q, status_d;

  logic core_rst_q, core_rst_d;
  logic core_stall_q, core_stall_d;
  logic ld_ready_q, ld_ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic             accept;
  logic             at_last_addr;
  logic [CYC_W-1:0] used_inc;

  assign accept       = (state_q == StLoad) && ld_valid && ld_ready_q;
  assign at_last_addr = (addr_q == AW'(IMEM_DEPTH - 1));
  assign used_inc     = (used_q == '1) ? used_q : used_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    budget_d = budget_q;
    used_d   = used_q;
    status_d = status_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StLoad;
          addr_d   = '0;
          status_d = StatNone;
          used_d   = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          addr_d = addr_q + 1'b1;
          if (ld_last) begin
            state_d = StRelease;
          end else if (at_last_addr) begin
            // IMEM full with no end marker: never release the core.
            state_d  = StDone;
            status_d = StatOverflow;
          end
        end
      end
      StRelease: begin
        budget_d = run_cycles;
        if (run_cycles == '0) begin
          state_d  = StDone;
          status_d = StatBudget;
          used_d   = '0;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        used_d = used_inc;
        // Halt takes priority over budget exhaustion in the same cycle.
        if (halt) begin
          state_d  = StDone;
          status_d = StatHalted;
        end else if (used_inc == budget_q) begin
          state_d  = StDone;
          status_d = StatBudget;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered outputs are decoded from the next state.
    core_rst_d   = (state_d == StIdle) || (state_d == StLoad) || (state_d == StRelease);
    core_stall_d = (state_d == StDone);
    ld_ready_d   = (state_d == StLoad);
    busy_d       = (state_d == StLoad) || (state_d == StRelease) || (state_d == StRun);
    done_d       = (state_d == StDone) && (state_q != StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      budget_q     <= '0;
      used_q       <= '0;
      status_q     <= StatNone;
      core_rst_q   <= 1'b1;
      core_stall_q <= 1'b0;
      ld_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      budget_q     <= budget_d;
      used_q       <= used_d;
      status_q     <= status_d;
      core_rst_q   <= core_rst_d;
      core_stall_q <= core_stall_d;
      ld_ready_q   <= ld_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign imem_we     = accept;
  assign imem_addr   = addr_q;
  assign imem_wdata  = ld_data;
  assign ld_ready    = ld_ready_q;
  assign core_rst    = core_rst_q;
  assign core_stall  = core_stall_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign status      = status_q;
  assign cycles_used = used_q;

endmodule
